// File: rtl/ysyx_23060332_lsu_if.sv
// Memory-side bus of the LSU: a single-outstanding valid/ready request channel
// plus a read-data/write-acknowledge return.
interface ysyx_23060332_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic              wen;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output valid, wen, addr, wdata, wstrb,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, wen, addr, wdata, wstrb,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/ysyx_23060332_lsu.sv
// Load/store unit: one request at a time, lane-shifts stores, extends loads.
// Macro YSYX_23060332_LSU_MISALIGN_CHK_EN: misaligned half/word skip the bus with rsp_err=1.
module ysyx_23060332_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [4:0]          req_rd,
  ysyx_23060332_lsu_if.master bus,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_reg_wen,
  output logic [4:0]          rsp_rd,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic                busy
);
  // IDLE: accept request | REQ: bus_valid held | WAIT: await rvalid | RESP: hold response
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic              wen_q, wen_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [4:0]        rd_q, rd_d;
  logic [1:0]        off_q, off_d;
  logic              bus_valid_q, bus_valid_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]        bus_wstrb_q, bus_wstrb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_reg_wen_q, rsp_reg_wen_d;

  logic [1:0]        acc_off;
  logic [DATA_W-1:0] lane_wdata;
  logic [3:0]        lane_wstrb;
  logic [DATA_W-1:0] tmp;
  logic [DATA_W-1:0] load_data;

`ifdef YSYX_23060332_LSU_MISALIGN_CHK_EN
  logic rsp_err_q, rsp_err_d;
  logic misalign;
`endif

  always_comb begin
`ifdef YSYX_23060332_LSU_MISALIGN_CHK_EN
    acc_off  = req_addr[1:0];
    misalign = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
`else
    // Without the check, misaligned accesses are silently rounded down to natural alignment.
    case (req_size)
      2'b00:   acc_off = req_addr[1:0];
      2'b01:   acc_off = {req_addr[1], 1'b0};
      default: acc_off = 2'b00;
    endcase
`endif
    case (req_size)
      2'b00: begin
        lane_wdata = {4{req_wdata[7:0]}};
        lane_wstrb = 4'b0001 << acc_off;
      end
      2'b01: begin
        lane_wdata = {2{req_wdata[15:0]}};
        lane_wstrb = 4'b0011 << acc_off;
      end
      default: begin
        lane_wdata = req_wdata;
        lane_wstrb = 4'b1111;
      end
    endcase

    tmp = bus.rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_data = uns_q ? {{(DATA_W-8){1'b0}}, tmp[7:0]}
                                 : {{(DATA_W-8){tmp[7]}}, tmp[7:0]};
      2'b01:   load_data = uns_q ? {{(DATA_W-16){1'b0}}, tmp[15:0]}
                                 : {{(DATA_W-16){tmp[15]}}, tmp[15:0]};
      default: load_data = tmp;
    endcase

    state_d       = state_q;
    wen_d         = wen_q;
    size_d        = size_q;
    uns_d         = uns_q;
    rd_d          = rd_q;
    off_d         = off_q;
    bus_valid_d   = bus_valid_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    bus_wstrb_d   = bus_wstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_reg_wen_d = rsp_reg_wen_q;
`ifdef YSYX_23060332_LSU_MISALIGN_CHK_EN
    rsp_err_d     = rsp_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wen_d       = req_wen;
          size_d      = req_size;
          uns_d       = req_unsigned;
          rd_d        = req_rd;
          off_d       = acc_off;
          bus_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
          bus_wdata_d = lane_wdata;
          bus_wstrb_d = lane_wstrb;
`ifdef YSYX_23060332_LSU_MISALIGN_CHK_EN
          if (misalign) begin
            state_d       = S_RESP;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_data_d    = DATA_W'(req_addr);
            rsp_reg_wen_d = 1'b0;
          end else begin
            state_d     = S_REQ;
            bus_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
          end
`else
          state_d     = S_REQ;
          bus_valid_d = 1'b1;
`endif
        end
      end
      S_REQ: begin
        if (bus.ready) begin
          state_d     = S_WAIT;
          bus_valid_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (bus.rvalid) begin
          state_d       = S_RESP;
          rsp_valid_d   = 1'b1;
          rsp_data_d    = wen_q ? '0 : load_data;
          rsp_reg_wen_d = !wen_q && (rd_q != 5'd0);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d       = S_IDLE;
          rsp_valid_d   = 1'b0;
          rsp_reg_wen_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wen_q         <= 1'b0;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      rd_q          <= 5'd0;
      off_q         <= 2'b00;
      bus_valid_q   <= 1'b0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      bus_wstrb_q   <= 4'b0000;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_reg_wen_q <= 1'b0;
`ifdef YSYX_23060332_LSU_MISALIGN_CHK_EN
      rsp_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      wen_q         <= wen_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      rd_q          <= rd_d;
      off_q         <= off_d;
      bus_valid_q   <= bus_valid_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      bus_wstrb_q   <= bus_wstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_reg_wen_q <= rsp_reg_wen_d;
`ifdef YSYX_23060332_LSU_MISALIGN_CHK_EN
      rsp_err_q     <= rsp_err_d;
`endif
    end
  end

  // req_ready is gated by rst_n so every output reads 0 while reset is held.
  assign req_ready   = rst_n && (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign bus.valid   = bus_valid_q;
  assign bus.wen     = wen_q;
  assign bus.addr    = bus_addr_q;
  assign bus.wdata   = bus_wdata_q;
  assign bus.wstrb   = bus_wstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_reg_wen = rsp_reg_wen_q;
  assign rsp_rd      = rd_q;
`ifdef YSYX_23060332_LSU_MISALIGN_CHK_EN
  assign rsp_err     = rsp_err_q;
`else
  assign rsp_err     = 1'b0;
`endif
endmodule

// File: doc/ysyx_23060332_lsu.md
# ysyx_23060332_lsu

Load/store unit sitting directly downstream of the execute stage. It accepts one memory request at a time: address, store data, access size and load sign mode. It drives a single-outstanding valid/ready memory bus and returns a response carrying the aligned, sign- or zero-extended load data for register writeback. While a request is in flight it back-pressures the execute stage.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width. Only 32 is supported.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_wen` in 1: 1 = store, 0 = load.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in DATA_W: store data, right-justified.
- `req_size` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `req_unsigned` in 1: zero-extend the load (LBU/LHU).
- `req_rd` in 5: destination register.
- `bus_valid` out 1: bus request.
- `bus_ready` in 1: bus accepted the request.
- `bus_wen` out 1: bus write.
- `bus_addr` out ADDR_W: word-aligned address (low 2 bits = 0).
- `bus_wdata` out DATA_W: lane-shifted store data.
- `bus_wstrb` out 4: byte strobes.
- `bus_rvalid` in 1: read data valid, or write acknowledge.
- `bus_rdata` in DATA_W: read word.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_reg_wen` out 1: write `rsp_data` to `rsp_rd`.
- `rsp_rd` out 5: destination register.
- `rsp_data` out DATA_W: extended load data.
- `rsp_err` out 1: misaligned access.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch all request fields and go to REQ.
- REQ:
  - `bus_valid` = 1. Bus fields are driven from registered values and stay stable until `bus_ready`.
  - On `bus_ready`, go to WAIT.
- WAIT:
  - On `bus_rvalid`, capture `bus_rdata` and go to RESP.
  - `bus_rvalid` is ignored in every state except WAIT.
- RESP:
  - `rsp_valid` = 1; response fields are held stable.
  - On `rsp_ready`, go to IDLE.
- Store lanes, with `off` = `addr[1:0]`:
  - Byte: `wdata` = `{4{wdata[7:0]}}`, `wstrb` = 0001<<`off`.
  - Half: `wdata` = `{2{wdata[15:0]}}`, `wstrb` = 0011<<`off`.
  - Word: `wstrb` = 1111.
- Load extraction:
  - `tmp` = `rdata` >> (8·`off`).
  - Byte: bits [7:0], half: bits [15:0].
  - Sign-extend unless `req_unsigned`; word loads are passed through unchanged.
- `rsp_reg_wen` = load AND NOT `rsp_err` AND `rsp_rd` != 0.
- Store responses return `rsp_data` = 0 and `rsp_reg_wen` = 0.

## Timing
- Reset (async, `rst_n` = 0):
  - State returns to IDLE; every output register is cleared to 0.
  - `req_ready` = 1 as soon as reset releases.
  - An in-flight bus transaction is abandoned; the bus is reset together with this unit.
- Minimum latency, with `bus_ready` and `bus_rvalid` at the first opportunity:
  - Cycle 0: accept.
  - Cycle 1: `bus_valid`.
  - Cycle 2: `rvalid`.
  - Cycle 3: `rsp_valid`.
  - Cycle 4: earliest next accept, if `rsp_ready` was high in cycle 3.
- Back-to-back: there is no accept in the same cycle as a RESP handshake. Throughput is one request per 4 cycles at best.
- `bus_valid` never drops before `bus_ready`.
- `rsp_valid` never drops before `rsp_ready`.
- Unbounded bus stalls hold REQ or WAIT indefinitely. There is no timeout.

## Configuration
- Macro: `YSYX_23060332_LSU_MISALIGN_CHK_EN`.
- Defined:
  - A half access with `addr[0]` = 1, or a word access with `addr[1:0]` != 0, skips the bus.
  - The unit goes IDLE→RESP directly (response in cycle 1), with `rsp_err` = 1, `rsp_data` = `req_addr`, `rsp_reg_wen` = 0.
  - `bus_valid` never asserts for that request.
- Undefined:
  - The low address bits are cleared to the size's natural alignment before lane and strobe computation.
  - `rsp_err` is tied to 0.

## Test plan
- LW at addr 0x100, bus returns 0xDEADBEEF with `bus_ready`/`bus_rvalid` immediate → `rsp_valid` in cycle 3, `rsp_data` = 0xDEADBEEF, `rsp_reg_wen` = 1.
- LB at addr 0x103, rdata 0x80123456 → `rsp_data` = 0xFFFFFF80. The same access as LBU → 0x00000080.
- SH at addr 0x102, wdata 0x0000ABCD → `bus_addr` 0x100, `bus_wdata` 0xABCDABCD, `bus_wstrb` 1100, `bus_wen` = 1, `rsp_reg_wen` = 0.
- `bus_ready` low for 5 cycles, then `rsp_ready` low for 3 cycles → `bus_valid`/fields stable throughout, `req_ready` = 0 until the RESP handshake completes.
- Assert `rst_n` = 0 during WAIT → all outputs 0 asynchronously. After release `req_ready` = 1, and a stale `bus_rvalid` produces no response.
- With the macro: LW at 0x102 → `rsp_err` = 1, `rsp_data` = 0x102, no `bus_valid`. Without the macro: same request → `bus_addr` 0x100, `rsp_err` = 0.
